// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: default geometry,
// per-stage control layout, flag positions and the full-adder / overflow helpers.
package pipelined_addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int CW         = DEF_WIDTH / DEF_STAGES;

  localparam int FLAG_COUT  = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int NUM_FLAGS  = 3;

  // Fixed-width part of a stage register; the partial sum and the not yet
  // consumed operand bits are WIDTH-dependent and sit beside it in the top.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctl_t;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sum_msb);
    signed_ovf = (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_addsub_chunk.sv
// CHUNK_W-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
module addsub_chunk
  import pipelined_addsub_pkg::*;
#(
  parameter int CHUNK_W = CW
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s,
  output logic               co
);

  logic [CHUNK_W-1:0] sum_s;
  logic               carry_s;
  logic [1:0]         fa_s;

  // Ripple the carry through one full-adder cell per bit
  always_comb begin
    sum_s   = {CHUNK_W{1'b0}};
    carry_s = ci;
    fa_s    = 2'b00;
    for (int i = 0; i < CHUNK_W; i++) begin
      fa_s     = full_add(a[i], b[i], carry_s);
      sum_s[i] = fa_s[0];
      carry_s  = fa_s[1];
    end
  end

  assign s  = sum_s;
  assign co = carry_s;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: stage s adds chunk s and hands its
// carry, the partial sum and the untouched operand bits to stage s+1. STAGES >= 2.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CWL = WIDTH / STAGES;

  logic                 en_s;
  logic                 take_s;
  logic                 rst_done_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     b_eff_s;
  logic [WIDTH-1:0]     sum_r;
  logic [NUM_FLAGS-1:0] flags_r;

  // Values entering each stage: stage 0 from the ports, later ones from registers
  stage_ctl_t       ctl_in    [STAGES];
  logic [WIDTH-1:0] a_in      [STAGES];
  logic [WIDTH-1:0] b_in      [STAGES];
  logic [WIDTH-1:0] ps_in     [STAGES];
  logic [WIDTH-1:0] ps_next   [STAGES];
  logic [CWL-1:0]   chunk_sum [STAGES];
  logic             chunk_co  [STAGES];

  // in_ready stays low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
    end
  end

  // The whole pipeline moves as one; a stalled output freezes every stage
  assign en_s     = !out_valid_r || out_ready;
  assign in_ready = en_s && rst_done_r;
  assign take_s   = in_valid && in_ready;
  assign b_eff_s  = sub ? ~b : b;

  assign ctl_in[0] = '{valid: take_s,
                       carry: (sub ? 1'b1 : cin),
                       a_msb: a[WIDTH-1],
                       b_msb: b_eff_s[WIDTH-1]};
  assign a_in[0]   = a;
  assign b_in[0]   = b_eff_s;
  assign ps_in[0]  = {WIDTH{1'b0}};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    addsub_chunk #(.CHUNK_W(CWL)) u_chunk (
      .a  (a_in[s][s*CWL +: CWL]),
      .b  (b_in[s][s*CWL +: CWL]),
      .ci (ctl_in[s].carry),
      .s  (chunk_sum[s]),
      .co (chunk_co[s])
    );

    assign ps_next[s] = ps_in[s] | ({{(WIDTH-CWL){1'b0}}, chunk_sum[s]} << (s*CWL));

    if (s < STAGES-1) begin : g_mid
      // Consumed operand bits are zeroed so only the still-needed upper part is carried
      localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << ((s+1)*CWL);

      stage_ctl_t       ctl_r;
      logic [WIDTH-1:0] ps_r;
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;

      // Intermediate stage register; flush only kills the valid bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctl_r <= '{valid: 1'b0, carry: 1'b0, a_msb: 1'b0, b_msb: 1'b0};
          ps_r  <= {WIDTH{1'b0}};
          a_r   <= {WIDTH{1'b0}};
          b_r   <= {WIDTH{1'b0}};
        end else if (flush) begin
          ctl_r.valid <= 1'b0;
        end else if (en_s) begin
          ctl_r <= '{valid: ctl_in[s].valid,
                     carry: chunk_co[s],
                     a_msb: ctl_in[s].a_msb,
                     b_msb: ctl_in[s].b_msb};
          ps_r  <= ps_next[s];
          a_r   <= a_in[s] & KEEP;
          b_r   <= b_in[s] & KEEP;
        end
      end

      assign ctl_in[s+1] = ctl_r;
      assign ps_in[s+1]  = ps_r;
      assign a_in[s+1]   = a_r;
      assign b_in[s+1]   = b_r;
    end else begin : g_last
      // Final stage doubles as the output register and derives the flags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_r <= 1'b0;
          sum_r       <= {WIDTH{1'b0}};
          flags_r     <= {NUM_FLAGS{1'b0}};
        end else if (flush) begin
          out_valid_r <= 1'b0;
        end else if (en_s) begin
          out_valid_r        <= ctl_in[s].valid;
          sum_r              <= ps_next[s];
          flags_r[FLAG_COUT] <= chunk_co[s];
          flags_r[FLAG_OVF]  <= signed_ovf(ctl_in[s].a_msb, ctl_in[s].b_msb,
                                           ps_next[s][WIDTH-1]);
          flags_r[FLAG_ZERO] <= (ps_next[s] == {WIDTH{1'b0}});
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = flags_r[FLAG_COUT];
  assign ovf       = flags_r[FLAG_OVF];
  assign zero      = flags_r[FLAG_ZERO];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corner cases plus random
// streams compared against an arithmetic reference model and result queue.
`timescale 1ns/1ps
module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    res_t         res;
  } dir_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: exact integer arithmetic, then wrap to W bits.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic c);
    res_t     r;
    longint   exact;
    logic [W:0] wide;
    if (s) begin
      exact  = longint'($signed(x)) - longint'($signed(y));
      r.sum  = x - y;
      r.cout = (x >= y);
    end else begin
      exact  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      wide   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r.sum  = wide[W-1:0];
      r.cout = wide[W];
    end
    r.ovf  = (exact != longint'($signed(r.sum)));
    r.zero = (r.sum == {W{1'b0}});
    return r;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] edges [5];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'hFFFF_FFFF;
    edges[2] = 32'h8000_0000;
    edges[3] = 32'h7FFF_FFFF;
    edges[4] = 32'h00FF_FFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic c);
    in_valid = v;
    a        = x;
    b        = y;
    sub      = s;
    cin      = c;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
  endtask

  // Model bookkeeping for the coming edge: retire the presented result, log an accept.
  task automatic book();
    #1;
    if (out_valid && out_ready && exp_q.size() > 0) exp_q.delete(0);
    if (flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cin));
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, sum, cout, ovf, zero} !== {(W+4){1'b0}}) begin
      n_err++;
      $display("FAIL reset_outputs got ov=%b sum=%h c=%b o=%b z=%b exp all 0",
               out_valid, sum, cout, ovf, zero);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL release_in_ready got %b exp 0", in_ready);
    end
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_after_release got %b exp 1", in_ready);
    end
    exp_q.delete();
  endtask

  task automatic test_directed();
    dir_t cases [6];
    int   lat;
    cases[0] = '{a: 32'h0000_0001, b: 32'hFFFF_FFFF, sub: 1'b0, cin: 1'b0,
                 res: '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1}};
    cases[1] = '{a: 32'h8000_0000, b: 32'h0000_0001, sub: 1'b1, cin: 1'b0,
                 res: '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0}};
    cases[2] = '{a: 32'h0000_0005, b: 32'h0000_0007, sub: 1'b1, cin: 1'b1,
                 res: '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0}};
    cases[3] = '{a: 32'h00FF_FFFF, b: 32'h0000_0001, sub: 1'b0, cin: 1'b0,
                 res: '{sum: 32'h0100_0000, cout: 1'b0, ovf: 1'b0, zero: 1'b0}};
    cases[4] = '{a: 32'h00FF_FFFF, b: 32'h0000_0000, sub: 1'b0, cin: 1'b1,
                 res: '{sum: 32'h0100_0000, cout: 1'b0, ovf: 1'b0, zero: 1'b0}};
    cases[5] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, sub: 1'b0, cin: 1'b0,
                 res: '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0}};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, cases[i].a, cases[i].b, cases[i].sub, cases[i].cin);
      book();
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      lat = 1;
      while (!out_valid && lat < 10) begin
        book();
        tick();
        lat++;
      end
      n_vec++;
      if (lat !== S) begin
        n_err++;
        $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, S);
      end
      n_vec++;
      if ({sum, cout, ovf, zero} !== cases[i].res) begin
        n_err++;
        $display("FAIL dir%0d_result got sum=%h c=%b o=%b z=%b exp sum=%h c=%b o=%b z=%b",
                 i, sum, cout, ovf, zero, cases[i].res.sum, cases[i].res.cout,
                 cases[i].res.ovf, cases[i].res.zero);
      end
      book();
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_single got out_valid=%b exp 0", i, out_valid);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int got   = 0;
    int first = -1;
    int last  = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_spurious got sum=%h exp no result", sum);
        end else if ({sum, cout, ovf, zero} !== exp_q[0]) begin
          n_err++;
          $display("FAIL b2b_result got %h exp %h", {sum, cout, ovf, zero}, exp_q[0]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      drive_rand(cyc < 16);
      book();
      tick();
    end
    n_vec++;
    if (got !== 16) begin
      n_err++;
      $display("FAIL b2b_count got %0d exp 16", got);
    end
    n_vec++;
    if (first !== S || last - first !== 15) begin
      n_err++;
      $display("FAIL b2b_timing got first=%0d span=%0d exp first=%0d span=15",
               first, last - first, S);
    end
  endtask

  task automatic test_stall();
    int got = 0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < S; cyc++) begin
      drive_rand(1'b1);
      book();
      tick();
    end
    drive_rand(1'b1);
    n_vec++;
    if (exp_q.size() !== S) begin
      n_err++;
      $display("FAIL stall_fill_count got %0d exp %0d", exp_q.size(), S);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold got in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid);
      end
      n_vec++;
      if (exp_q.size() == 0 || {sum, cout, ovf, zero} !== exp_q[0]) begin
        n_err++;
        $display("FAIL stall_stable got %h exp %h", {sum, cout, ovf, zero},
                 (exp_q.size() > 0) ? exp_q[0] : '0);
      end
      book();
      tick();
    end
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0 || {sum, cout, ovf, zero} !== exp_q[0]) begin
          n_err++;
          $display("FAIL stall_drain got %h exp %h", {sum, cout, ovf, zero},
                   (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        got++;
      end
      book();
      tick();
    end
    n_vec++;
    if (got !== S || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL stall_drain_count got %0d left=%0d exp %0d left=0", got, exp_q.size(), S);
    end
  endtask

  task automatic test_random();
    exp_q.delete();
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0 || {sum, cout, ovf, zero} !== exp_q[0]) begin
          n_err++;
          $display("FAIL random_result cyc %0d got %h exp %h", cyc, {sum, cout, ovf, zero},
                   (exp_q.size() > 0) ? exp_q[0] : '0);
        end
      end
      if (cyc < 120) begin
        drive_rand($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
      end
      book();
      tick();
    end
    n_vec++;
    if (exp_q.size() !== 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_lost got left=%0d out_valid=%b exp 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_flush_reset();
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      book();
      tick();
    end
    drive_rand(1'b1);
    flush = 1'b1;
    book();
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_no_out cyc %0d got out_valid=%b exp 0", i, out_valid);
      end
      book();
      tick();
    end
    for (int i = 0; i < S; i++) begin
      drive_rand(1'b1);
      book();
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_valid got out_valid=%b exp 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, sum, cout, ovf, zero} !== {(W+4){1'b0}}) begin
      n_err++;
      $display("FAIL rst_async_clear got ov=%b sum=%h c=%b o=%b z=%b exp all 0",
               out_valid, sum, cout, ovf, zero);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_discard cyc %0d got out_valid=%b exp 0", i, out_valid);
      end
      book();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
